// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered, write-bypassed reads and a one-entry-per-cycle clear sweep.
// Optional REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              we_,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_re_,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_re_,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              clr_,
  output logic              busy
);

  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  DEPTH_C = CMP_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a == '0;
`else
    return (a == '0) && 1'b0;
`endif
  endfunction

  // Write-first bypass, then storage, then zero for out-of-range addresses.
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!we_ && (wr_addr == a)) v = wr_data;
    else if (in_range(a))       v = mem[a];
    if (is_zero_reg(a))         v = '0;
    return v;
  endfunction

  assign wr_ok = !we_ && in_range(wr_addr) && !is_zero_reg(wr_addr);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd0_data <= '0;
      rd1_data <= '0;
      busy     <= 1'b0;
      state    <= IDLE;
      clr_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rd0_re_) rd0_data <= rd_val(rd0_addr);
          if (!rd1_re_) rd1_data <= rd_val(rd1_addr);
          // Clear request wins over a write in the same cycle.
          if (!clr_) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
          end
        end
        CLEAR: begin
          mem[clr_cnt] <= '0;
          if (clr_cnt == LAST_C) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: expected read data queued at issue, compared one cycle later.
module tb_regfile_2r1w;
  localparam int unsigned DW = 32;
  localparam int unsigned DP = 32;
  localparam int unsigned AW = 5;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_;
  logic          we_ = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd0_re_ = 1'b1;
  logic [AW-1:0] rd0_addr = '0;
  logic [DW-1:0] rd0_data;
  logic          rd1_re_ = 1'b1;
  logic [AW-1:0] rd1_addr = '0;
  logic [DW-1:0] rd1_data;
  logic          clr_ = 1'b1;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [DP];
  bit            mbusy;
  int            mcnt;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  regfile_2r1w #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .reset_(reset_), .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_re_(rd0_re_), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_re_(rd1_re_), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .clr_(clr_), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_read(input logic we, input logic [AW-1:0] wa,
                                             input logic [DW-1:0] wd, input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    if (ZERO && ra == 0)        v = '0;
    else if (!we && wa == ra)   v = wd;
    else if (int'(ra) < int'(DP)) v = mdl[ra];
    else                        v = '0;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DP); i++) mdl[i] = '0;
    mbusy = 1'b0;
    mcnt  = 0;
    q0.delete();
    q1.delete();
  endtask

  // Drive one cycle, update the reference model, queue expected read data, then sample after the edge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic r0e, input logic [AW-1:0] r0a,
                      input logic r1e, input logic [AW-1:0] r1a, input logic clr);
    we_ = we; wr_addr = wa; wr_data = wd;
    rd0_re_ = r0e; rd0_addr = r0a; rd1_re_ = r1e; rd1_addr = r1a; clr_ = clr;
    if (!mbusy) begin
      if (!r0e) q0.push_back(exp_read(we, wa, wd, r0a));
      if (!r1e) q1.push_back(exp_read(we, wa, wd, r1a));
      if (!clr) begin
        mbusy = 1'b1;
        mcnt  = 0;
      end else if (!we && int'(wa) < int'(DP) && !(ZERO && wa == 0)) begin
        mdl[wa] = wd;
      end
    end else begin
      mdl[mcnt] = '0;
      if (mcnt == int'(DP) - 1) begin
        mbusy = 1'b0;
        mcnt  = 0;
      end else begin
        mcnt++;
      end
    end
    @(posedge clk);
    #1;
    we_ = 1'b1; rd0_re_ = 1'b1; rd1_re_ = 1'b1; clr_ = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    model_reset();
    #12;
    checks++;
    if (rd0_data !== '0 || rd1_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rd0=%h rd1=%h busy=%b, required 0/0/0", rd0_data, rd1_data, busy);
    end
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(DP); i++) begin
      step(1'b1, '0, '0, 1'b0, AW'(i), 1'b0, AW'(DP - 1 - i), 1'b1);
      checks++;
      if (rd0_data !== q0.pop_front() || rd1_data !== q1.pop_front() || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_read[%0d]: rd0=%h rd1=%h busy=%b, required zeros", i, rd0_data, rd1_data, busy);
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] e0, e1;
    step(1'b0, AW'(5), 32'hDEADBEEF, 1'b1, '0, 1'b1, '0, 1'b1);
    step(1'b1, '0, '0, 1'b0, AW'(5), 1'b0, AW'(6), 1'b1);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (rd0_data !== e0 || e0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read rd0: got %h, required %h", rd0_data, 32'hDEADBEEF);
    end
    checks++;
    if (rd1_data !== e1 || e1 !== '0) begin
      errors++;
      $display("FAIL write_read rd1: got %h, required 0", rd1_data);
    end
  endtask

  task automatic test_bypass();
    for (int k = 0; k < 2; k++) begin
      step(k == 0 ? 1'b0 : 1'b1, AW'(9), 32'h12345678, 1'b0, AW'(9), 1'b0, AW'(9), 1'b1);
      checks++;
      if (rd0_data !== q0.pop_front() || rd1_data !== q1.pop_front() || rd0_data !== 32'h12345678) begin
        errors++;
        $display("FAIL bypass[%0d]: rd0=%h rd1=%h, required 12345678", k, rd0_data, rd1_data);
      end
    end
  endtask

  task automatic test_clear();
    int cnt;
    logic [DW-1:0] h0, h1;
    for (int i = 0; i < int'(DP); i++)
      step(1'b0, AW'(i), 32'hA5A50000 + DW'(i), 1'b1, '0, 1'b1, '0, 1'b1);
    // Clear start cycle: write to 1 dropped, reads return pre-clear contents (port 1 bypasses).
    step(1'b0, AW'(1), 32'h0BAD0BAD, 1'b0, AW'(7), 1'b0, AW'(1), 1'b0);
    h0 = q0.pop_front();
    h1 = q1.pop_front();
    checks++;
    if (rd0_data !== h0 || rd0_data !== 32'hA5A50007 || rd1_data !== h1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_start: rd0=%h rd1=%h busy=%b, required %h %h 1", rd0_data, rd1_data, busy, h0, h1);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      step(1'b0, AW'($urandom_range(0, DP - 1)), $urandom, 1'b0, AW'(cnt % DP), 1'b0, AW'(2),
           (cnt % 5 == 0) ? 1'b0 : 1'b1);
      checks++;
      if (rd0_data !== h0 || rd1_data !== h1) begin
        errors++;
        $display("FAIL clear_hold[%0d]: rd0=%h rd1=%h, required %h %h", cnt, rd0_data, rd1_data, h0, h1);
      end
    end
    checks++;
    if (cnt !== int'(DP)) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles, required %0d", cnt, DP);
    end
    for (int i = 0; i < int'(DP); i++) begin
      step(1'b1, '0, '0, 1'b0, AW'(i), 1'b0, AW'(i), 1'b1);
      checks++;
      if (rd0_data !== q0.pop_front() || rd1_data !== q1.pop_front() || rd0_data !== '0) begin
        errors++;
        $display("FAIL clear_after[%0d]: rd0=%h rd1=%h, required 0", i, rd0_data, rd1_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < int'(DP); i++)
      step(1'b0, AW'(i), 32'h11110000 + DW'(i), 1'b1, '0, 1'b1, '0, 1'b1);
    step(1'b1, '0, '0, 1'b1, '0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, '0, '0, 1'b1, '0, 1'b1, '0, 1'b1);
    reset_ = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear busy: got %b, required 0", busy);
    end
    #2;
    reset_ = 1'b1;
    step(1'b0, AW'(3), 32'h55, 1'b0, AW'(20), 1'b0, AW'(30), 1'b1);
    checks++;
    if (rd0_data !== q0.pop_front() || rd1_data !== q1.pop_front() || rd0_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear first: rd0=%h rd1=%h, required 0", rd0_data, rd1_data);
    end
    for (int i = 0; i < int'(DP); i++) begin
      step(1'b1, '0, '0, 1'b0, AW'(i), 1'b0, AW'(DP - 1 - i), 1'b1);
      checks++;
      if (rd0_data !== q0.pop_front() || rd1_data !== q1.pop_front() ||
          rd0_data !== ((i == 3) ? 32'h55 : 32'h0)) begin
        errors++;
        $display("FAIL reset_mid_clear read[%0d]: rd0=%h rd1=%h", i, rd0_data, rd1_data);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] req;
    req = ZERO ? 32'h0 : 32'hFFFFFFFF;
    step(1'b0, '0, 32'hFFFFFFFF, 1'b0, '0, 1'b1, '0, 1'b1);
    checks++;
    if (rd0_data !== q0.pop_front() || rd0_data !== req) begin
      errors++;
      $display("FAIL zero_reg bypass: got %h, required %h", rd0_data, req);
    end
    step(1'b1, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    checks++;
    if (rd0_data !== q0.pop_front() || rd1_data !== q1.pop_front() || rd1_data !== req) begin
      errors++;
      $display("FAIL zero_reg stored: rd0=%h rd1=%h, required %h", rd0_data, rd1_data, req);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      step($urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, AW'($urandom_range(0, DP - 1)), d,
           1'b0, AW'($urandom_range(0, DP - 1)), $urandom_range(0, 3) == 0 ? 1'b1 : 1'b0,
           AW'($urandom_range(0, DP - 1)), 1'b1);
      checks++;
      if (rd0_data !== q0.pop_front()) begin
        errors++;
        $display("FAIL b2b rd0[%0d]: got %h", i, rd0_data);
      end
      if (q1.size() != 0) begin
        d = q1.pop_front();
        checks++;
        if (rd1_data !== d) begin
          errors++;
          $display("FAIL b2b rd1[%0d]: got %h, required %h", i, rd1_data, d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
